e4m3_mul_arbiter: RTL and testbench

- Shares one `float_multiplier_e4m3` instance between NUM_REQ requesters.
- Per requester: valid/ready request port. Shared: one response channel, tagged with the requester ID.
- The multiplier has no start strobe. The block sequences each operation by pulsing the multiplier's active-high reset, holding operands stable, waiting for its valid, and applying a watchdog timeout.

---
 rtl/e4m3_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/e4m3_mul_arbiter.sv | 135 +++++++++++++
 tb/tb_e4m3_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e4m3_pkg.sv
// Shared types and constants for the e4m3 multiplier arbiter.
package e4m3_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

  localparam int unsigned E4M3_W    = 8;
  localparam logic [7:0]  E4M3_ZERO = 8'h00;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i wins.
module rr_arbiter
  import e4m3_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int unsigned cand;

  // Scan NUM_REQ positions starting at ptr_i, wrapping, and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    if (en_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = 32'(ptr_i) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!any_o && req_i[cand]) begin
          any_o       = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = ID_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/e4m3_mul_arbiter.sv
// Shares one e4m3 multiplier between NUM_REQ requesters. Each operation is
// started by pulsing the multiplier reset, then guarded by a watchdog.
module e4m3_mul_arbiter
  import e4m3_pkg::*;
#(
  parameter int unsigned  NUM_REQ  = 4,
  parameter int unsigned  MAX_WAIT = 16,
  localparam int unsigned ID_W     = id_width(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [E4M3_W*NUM_REQ-1:0] req_a,
  input  logic [E4M3_W*NUM_REQ-1:0] req_b,
  output logic [E4M3_W-1:0]         mul_a,
  output logic [E4M3_W-1:0]         mul_b,
  output logic                      mul_reset,
  input  logic [E4M3_W-1:0]         mul_y,
  input  logic                      mul_valid,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [E4M3_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     rr_ptr_d;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [E4M3_W-1:0]   mul_a_q;
  logic [E4M3_W-1:0]   mul_b_q;
  logic                mul_reset_q;
  logic                resp_valid_q;
  logic [E4M3_W-1:0]   resp_data_q;
  logic [ID_W-1:0]     resp_id_q;
  logic                resp_err_q;
  logic                busy_q;

  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                any_gnt;

  // Grants only in IDLE; reset_n gates it so req_ready is 0 while reset is held.
  assign arb_en = (state_q == StIdle) && reset_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_gnt)
  );

  // Search resumes just past the winner so each active requester gets a turn.
  assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Sequencer: grant, launch (multiplier held in reset), wait with watchdog, respond.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_reset_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= E4M3_ZERO;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_gnt) begin
            mul_a_q   <= req_a[E4M3_W*gnt_idx +: E4M3_W];
            mul_b_q   <= req_b[E4M3_W*gnt_idx +: E4M3_W];
            resp_id_q <= gnt_idx;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= 1'b1;
            state_q   <= StLaunch;
          end
        end
        StLaunch: begin
          // Multiplier has seen reset with the new operands; release it.
          wait_cnt_q  <= '0;
          mul_reset_q <= 1'b0;
          state_q     <= StWait;
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          // A valid result wins over a timeout landing on the same cycle.
          if (mul_valid) begin
            resp_data_q  <= mul_y;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            resp_data_q  <= E4M3_ZERO;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            mul_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
      endcase
    end
  end

  assign req_ready  = gnt;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_reset  = mul_reset_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_e4m3_mul_arbiter.sv
// Directed bench for e4m3_mul_arbiter with a behavioural e4m3 multiplier on mul_*.
module tb_e4m3_mul_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned MAX_WAIT = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [7:0]  mul_a, mul_b, mul_y;
  logic        mul_reset, mul_valid;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int k;

  always #5 clock = ~clock;

  e4m3_mul_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_reset  (mul_reset),
    .mul_y      (mul_y),
    .mul_valid  (mul_valid),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Behavioural multiplier: normals with exact products and signed zeros only.
  function automatic logic [7:0] e4m3_mul(input logic [7:0] a, input logic [7:0] b);
    logic       s;
    logic [7:0] p;
    logic [2:0] m;
    int         e;
    s = a[7] ^ b[7];
    if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return {s, 7'd0};
    p = 8'({1'b1, a[2:0]}) * 8'({1'b1, b[2:0]});
    e = int'(a[6:3]) + int'(b[6:3]) - 7;
    if (p[7]) begin
      e++;
      m = p[6:4];
    end else begin
      m = p[5:3];
    end
    return {s, e[3:0], m};
  endfunction

  // Multiplier timing: valid one cycle after reset release for zeros, three otherwise.
  logic [3:0] m_cnt = '0;
  logic       stub_dead = 1'b0;
  logic       m_zero;
  always @(posedge clock) begin
    if (mul_reset) m_cnt <= '0;
    else if (m_cnt != 4'hF) m_cnt <= m_cnt + 4'd1;
  end
  assign m_zero    = (mul_a[6:0] == 7'd0) || (mul_b[6:0] == 7'd0);
  assign mul_valid = !stub_dead && !mul_reset && (m_cnt >= (m_zero ? 4'd1 : 4'd3));
  assign mul_y     = e4m3_mul(mul_a, mul_b);

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (mul_reset !== 1'b1) $display("FAIL rst_mul_reset got %b want 1", mul_reset); else passes++;
    checks++; if ({mul_a, mul_b} !== 16'h0) $display("FAIL rst_mul_ab got %h want 0000", {mul_a, mul_b}); else passes++;
    checks++; if ({resp_valid, resp_err, busy} !== 3'b000) $display("FAIL rst_flags got %b want 000", {resp_valid, resp_err, busy}); else passes++;
    checks++; if ({resp_data, resp_id} !== 10'h0) $display("FAIL rst_resp got %h want 000", {resp_data, resp_id}); else passes++;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready got %b want 0000", req_ready); else passes++;
    req_valid = '0;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    req_a[7:0] = 8'h40; req_b[7:0] = 8'h44; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant got %b want 0001", req_ready); else passes++;
    @(posedge clock); #1;
    req_valid = '0;
    checks++; if ({busy, mul_reset, mul_a, mul_b} !== {2'b11, 16'h4044}) $display("FAIL single_launch got %h want 34044", {busy, mul_reset, mul_a, mul_b}); else passes++;
    k = 1;
    while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
    checks++; if (resp_valid !== 1'b1) $display("FAIL single_timeout got %b want 1", resp_valid); else passes++;
    checks++; if (resp_data !== 8'h4C) $display("FAIL single_data got %h want 4c", resp_data); else passes++;
    checks++; if ({resp_id, resp_err} !== 3'b000) $display("FAIL single_id_err got %b want 000", {resp_id, resp_err}); else passes++;
    @(posedge clock); #1;
    checks++; if ({busy, resp_valid, mul_reset} !== 3'b001) $display("FAIL single_idle got %b want 001", {busy, resp_valid, mul_reset}); else passes++;
  endtask

  task automatic test_zero();
    req_a[23:16] = 8'h80; req_b[23:16] = 8'h44; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL zero_grant got %b want 0100", req_ready); else passes++;
    @(posedge clock); #1;
    req_valid = '0;
    k = 1;
    while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
    checks++; if (k !== 4) $display("FAIL zero_latency got %0d want 4", k); else passes++;
    checks++; if (resp_data !== 8'h80) $display("FAIL zero_data got %h want 80", resp_data); else passes++;
    checks++; if ({resp_id, resp_err} !== 3'b100) $display("FAIL zero_id_err got %b want 100", {resp_id, resp_err}); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [6];
    logic [7:0] exp_d  [6];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_d  = '{8'h4C, 8'h3C, 8'hD0, 8'h41, 8'h4C, 8'h3C};
    reset_n = 1'b0;
    req_a = {8'h3C, 8'h48, 8'h38, 8'h40};
    req_b = {8'h3C, 8'hC0, 8'h3C, 8'h44};
    req_valid = 4'hF;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      k = 0;
      while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
      checks++; if (resp_id !== exp_id[n]) $display("FAIL rr_id[%0d] got %0d want %0d", n, resp_id, exp_id[n]); else passes++;
      checks++; if (resp_data !== exp_d[n]) $display("FAIL rr_data[%0d] got %h want %h", n, resp_data, exp_d[n]); else passes++;
      if (n == 5) req_valid = '0;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b0;
    req_a[15:8] = 8'h38; req_b[15:8] = 8'h3C;
    req_a[31:24] = 8'h3C; req_b[31:24] = 8'h3C;
    req_valid = 4'b0010;
    @(posedge clock); #1;
    req_valid = 4'b1000;
    k = 1;
    while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({resp_valid, resp_data, resp_id, resp_err, req_ready, mul_reset} !== {1'b1, 8'h3C, 2'd1, 1'b0, 4'b0000, 1'b0})
        $display("FAIL bp_hold[%0d] got %b_%h_%0d_%b_%b_%b want 1_3c_1_0_0000_0", i,
                 resp_valid, resp_data, resp_id, resp_err, req_ready, mul_reset);
      else passes++;
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b1) $display("FAIL bp_accept_valid got %b want 1", resp_valid); else passes++;
    @(posedge clock); #1;
    checks++; if ({busy, resp_valid, req_ready} !== 6'b001000) $display("FAIL bp_next_grant got %b want 001000", {busy, resp_valid, req_ready}); else passes++;
    @(posedge clock); #1;
    req_valid = '0;
    k = 1;
    while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
    checks++; if ({resp_id, resp_data} !== {2'd3, 8'h41}) $display("FAIL bp_second got %0d/%h want 3/41", resp_id, resp_data); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_timeout();
    stub_dead = 1'b1;
    req_a[7:0] = 8'h40; req_b[7:0] = 8'h44; req_valid = 4'b0001;
    @(posedge clock); #1;
    req_valid = '0;
    k = 1;
    while (!resp_valid && k < 60) begin @(posedge clock); #1; k++; end
    checks++; if (k !== 18) $display("FAIL to_latency got %0d want 18", k); else passes++;
    checks++; if ({resp_err, resp_data, resp_id} !== {1'b1, 8'h00, 2'd0}) $display("FAIL to_resp got %b/%h/%0d want 1/00/0", resp_err, resp_data, resp_id); else passes++;
    @(posedge clock); #1;
    stub_dead = 1'b0;
    req_a[23:16] = 8'h48; req_b[23:16] = 8'hC0; req_valid = 4'b0100;
    @(posedge clock); #1;
    req_valid = '0;
    k = 1;
    while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
    checks++; if ({resp_err, resp_data, resp_id} !== {1'b0, 8'hD0, 2'd2}) $display("FAIL to_recover got %b/%h/%0d want 0/d0/2", resp_err, resp_data, resp_id); else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_wait();
    req_a[15:8] = 8'h38; req_b[15:8] = 8'h3C; req_valid = 4'b0010;
    @(posedge clock); #1;
    req_valid = '0;
    repeat (2) begin @(posedge clock); #1; end
    checks++; if ({busy, mul_reset, mul_a} !== {2'b10, 8'h38}) $display("FAIL rw_in_wait got %b_%b_%h want 1_0_38", busy, mul_reset, mul_a); else passes++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, mul_reset, resp_valid, req_ready} !== 7'b0100000) $display("FAIL rw_async_ctrl got %b want 0100000", {busy, mul_reset, resp_valid, req_ready}); else passes++;
    checks++; if ({mul_a, mul_b, resp_data, resp_id, resp_err} !== 27'h0) $display("FAIL rw_async_data got %h want 0", {mul_a, mul_b, resp_data, resp_id, resp_err}); else passes++;
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rw_no_resp got %b want 0", resp_valid); else passes++;
    req_a[7:0] = 8'h40; req_b[7:0] = 8'h44; req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL rw_grant0 got %b want 0001", req_ready); else passes++;
    @(posedge clock); #1;
    req_valid = '0;
    k = 1;
    while (!resp_valid && k < 40) begin @(posedge clock); #1; k++; end
    checks++; if ({resp_id, resp_data, resp_err} !== {2'd0, 8'h4C, 1'b0}) $display("FAIL rw_after got %0d/%h/%b want 0/4c/0", resp_id, resp_data, resp_err); else passes++;
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
